// File: rtl/lc4_muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lc4_muldiv_seq_pkg
//  Brief    : Shared op codes, FSM states and iteration count for lc4_muldiv_seq
//  Revision : 1.0
// ============================================================================
package lc4_muldiv_seq_pkg;

    localparam logic OP_MUL    = 1'b0;
    localparam logic OP_DIVMOD = 1'b1;

    localparam int ITER = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lc4_muldiv_seq_cla16.sv
`default_nettype none
// ============================================================================
//  Module   : lc4_muldiv_seq_cla16
//  Brief    : 16-bit two-level carry-lookahead adder (4 groups of 4 bits)
//  Revision : 1.0
// ============================================================================
module lc4_muldiv_seq_cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  cg;

    assign g     = a & b;
    assign p     = a ^ b;
    assign cg[0] = cin;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_grp
            assign c[4*k]   = cg[k];
            assign c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            assign c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                            | (p[4*k+1] & p[4*k] & cg[k]);
            assign c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                            | (p[4*k+2] & p[4*k+1] & g[4*k])
                            | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);

            // Group carry-out only feeds the next group; the final carry is not exposed.
            if (k < 3) begin : g_next
                logic gg;
                logic gp;
                assign gp      = &p[4*k +: 4];
                assign gg      = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                               | (&p[4*k+1 +: 3] & g[4*k]);
                assign cg[k+1] = gg | (gp & cg[k]);
            end
        end
    endgenerate

    assign sum = p ^ c;

endmodule
`default_nettype wire

// File: rtl/lc4_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : lc4_muldiv_seq
//  Brief    : Iterative MUL / DIVMOD unit, one shared cla16 add per cycle
//  Revision : 1.0
// ============================================================================
module lc4_muldiv_seq
    import lc4_muldiv_seq_pkg::*;
#(
    parameter int W     = 16,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_res,
    output logic [W-1:0] out_rem
);

    state_t           state_q, state_d;
    logic             op_q, op_d;
    logic [W-1:0]     opa_q, opa_d;   // MUL: multiplicand, DIVMOD: dividend -> quotient
    logic [W-1:0]     opb_q, opb_d;   // MUL: multiplier,   DIVMOD: divisor
    logic [W-1:0]     acc_q, acc_d;   // MUL: accumulator,  DIVMOD: partial remainder
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     res_q, res_d;
    logic [W-1:0]     rem_q, rem_d;

    logic [W-1:0] cla_a;
    logic [W-1:0] cla_b;
    logic         cla_cin;
    logic [W-1:0] cla_sum;
    logic [W-1:0] shr;
    logic         top;
    logic         co;
    logic         ge;

    assign shr     = {acc_q[W-2:0], opa_q[W-1]};
    assign top     = acc_q[W-1];
    assign cla_a   = (op_q == OP_DIVMOD) ? shr : acc_q;
    assign cla_b   = (op_q == OP_DIVMOD) ? ~opb_q : opa_q;
    assign cla_cin = (op_q == OP_DIVMOD);

    lc4_muldiv_seq_cla16 u_cla16 (
        .a   (cla_a),
        .b   (cla_b),
        .cin (cla_cin),
        .sum (cla_sum)
    );

    // The adder has no carry-out, so rebuild it from the operand and sum MSBs.
    assign co = (shr[W-1] & ~opb_q[W-1]) | ((shr[W-1] ^ ~opb_q[W-1]) & ~cla_sum[W-1]);
    assign ge = top | co;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = in_op;
                    opa_d = in_a;
                    opb_d = in_b;
                    acc_d = '0;
                    cnt_d = '0;
                    if (in_op == OP_DIVMOD && in_b == '0) begin
                        state_d = DONE;
                        res_d   = '0;
                        rem_d   = '0;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (op_q == OP_MUL) begin
                    if (opb_q[0]) begin
                        acc_d = cla_sum;
                    end
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end else begin
                    acc_d = ge ? cla_sum : shr;
                    opa_d = {opa_q[W-2:0], ge};
                end
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = DONE;
                    res_d   = (op_q == OP_MUL) ? acc_d : opa_d;
                    rem_d   = (op_q == OP_MUL) ? '0 : acc_d;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_res   = res_q;
    assign out_rem   = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_lc4_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lc4_muldiv_seq
//  Brief    : Directed self-checking bench for lc4_muldiv_seq
//  Revision : 1.0
// ============================================================================
module tb_lc4_muldiv_seq;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_op     = 1'b0;
    logic [15:0] in_a      = 16'h0;
    logic [15:0] in_b      = 16'h0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_res;
    logic [15:0] out_rem;

    int n_vec = 0;
    int n_err = 0;

    lc4_muldiv_seq #(.W(16), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_rem   (out_rem)
    );

    always #5 clk = ~clk;

    // Reference: arithmetic result plus cycles remaining until the result shows.
    logic        m_idle;
    int          m_left;
    logic [15:0] m_res;
    logic [15:0] m_rem;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1'b1;
            m_left <= 0;
            m_res  <= 16'h0;
            m_rem  <= 16'h0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle <= 1'b0;
                if (in_op && in_b == 16'h0) begin
                    m_left <= 0;
                    m_res  <= 16'h0;
                    m_rem  <= 16'h0;
                end else begin
                    m_left <= 16;
                    if (!in_op) begin
                        m_res <= 16'(32'(in_a) * 32'(in_b));
                        m_rem <= 16'h0;
                    end else begin
                        m_res <= in_a / in_b;
                        m_rem <= in_a % in_b;
                    end
                end
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else if (out_ready) begin
            m_idle <= 1'b1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("in_ready", {31'b0, in_ready}, {31'b0, m_idle});
        check("out_valid", {31'b0, out_valid}, {31'b0, (!m_idle && m_left == 0)});
        if (!m_idle && m_left == 0) begin
            check("out_res", {16'b0, out_res}, {16'b0, m_res});
            check("out_rem", {16'b0, out_rem}, {16'b0, m_rem});
        end
    end

    task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic [15:0] ee,
                          input int lat, input int hold);
        int n;
        @(negedge clk);
        check("ready_before", {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = (hold == 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        check("latency", n, lat);
        check("res_lit", {16'b0, out_res}, {16'b0, er});
        check("rem_lit", {16'b0, out_rem}, {16'b0, ee});
        check("model_res_lit", {16'b0, m_res}, {16'b0, er});
        check("model_rem_lit", {16'b0, m_rem}, {16'b0, ee});
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 0);
            in_op    = 1'b0;
            in_a     = 16'h1234;
            in_b     = 16'h0003;
            @(negedge clk);
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_res", {16'b0, out_res}, {16'b0, er});
            check("hold_rem", {16'b0, out_rem}, {16'b0, ee});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_hs_valid", {31'b0, out_valid}, 32'd0);
        check("post_hs_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_res", {16'b0, out_res}, 32'd0);
        check("rst_out_rem", {16'b0, out_rem}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 16'd7,    16'd6,    16'h002A, 16'h0000, 17, 0);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 17, 0);
        run_op(1'b0, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 17, 0);
        run_op(1'b0, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 17, 0);
        run_op(1'b1, 16'd100,  16'd7,    16'd14,   16'd2,    17, 0);
        run_op(1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 17, 0);
        run_op(1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 17, 0);
        run_op(1'b1, 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 17, 0);
        run_op(1'b1, 16'd1234, 16'd0,    16'h0000, 16'h0000, 1,  0);
        run_op(1'b1, 16'd1000, 16'd33,   16'd30,   16'd10,   17, 5);

        // Abort mid-operation, then confirm the unit is usable again.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 1'b0;
        in_a     = 16'd9;
        in_b     = 16'd9;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", {31'b0, out_valid}, 32'd0);
        check("abort_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 16'd3, 16'd5, 16'd15, 16'd0, 17, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
